// File: rtl/sc_sng_pkg.sv
// Shared types and constants for the stochastic number generator bank.
// Holds the FSM state type, legal width bounds and XNOR LFSR tap masks.
package sc_sng_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sng_state_e;

  localparam int W_MIN = 3;
  localparam int W_MAX = 32;

  // Maximal-length XNOR taps; bit n-1 of the mask selects 1-indexed tap n.
  function automatic logic [31:0] lfsr_taps(input int w);
    logic [31:0] m;
    m = 32'h0;
    case (w)
      3:  m = 32'h0000_0006;
      4:  m = 32'h0000_000C;
      5:  m = 32'h0000_0014;
      6:  m = 32'h0000_0030;
      7:  m = 32'h0000_0060;
      8:  m = 32'h0000_00B8;
      9:  m = 32'h0000_0110;
      10: m = 32'h0000_0240;
      11: m = 32'h0000_0500;
      12: m = 32'h0000_0829;
      13: m = 32'h0000_100D;
      14: m = 32'h0000_2015;
      15: m = 32'h0000_6000;
      16: m = 32'h0000_D008;
      17: m = 32'h0001_2000;
      18: m = 32'h0002_0400;
      19: m = 32'h0004_0023;
      20: m = 32'h0009_0000;
      21: m = 32'h0014_0000;
      22: m = 32'h0030_0000;
      23: m = 32'h0042_0000;
      24: m = 32'h00E1_0000;
      25: m = 32'h0120_0000;
      26: m = 32'h0200_0023;
      27: m = 32'h0400_0013;
      28: m = 32'h0900_0000;
      29: m = 32'h1400_0000;
      30: m = 32'h2000_0029;
      31: m = 32'h4800_0000;
      32: m = 32'h8020_0003;
      default: m = 32'h0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/sc_lfsr_core.sv
// Single-channel XNOR-feedback LFSR with seed load and step enable.
// SNG_LOCKUP_GUARD_EN: replace an all-ones (lock-up) seed with all-zeros at load.
module sc_lfsr_core
  import sc_sng_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] seed,
  output logic [W-1:0] state
);

  localparam logic [31:0] TAPS = lfsr_taps(W);

  logic [W-1:0] r_state;
  logic [W-1:0] w_seed;
  logic         w_fb;

`ifdef SNG_LOCKUP_GUARD_EN
  assign w_seed = (&seed) ? '0 : seed;
`else
  assign w_seed = seed;
`endif

  // Parity of the masked bits equals the XOR of the taps; invert for XNOR.
  assign w_fb = ~(^(r_state & TAPS[W-1:0]));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= '0;
    end else if (load) begin
      r_state <= w_seed;
    end else if (step) begin
      r_state <= {r_state[W-2:0], w_fb};
    end
  end

  assign state = r_state;

endmodule

// File: rtl/sc_sng_bank.sv
// Multi-channel stochastic number generator with per-channel ones-counters.
// SNG_LOCKUP_GUARD_EN (handled in sc_lfsr_core) remaps all-ones seeds to zero.
module sc_sng_bank
  import sc_sng_pkg::*;
#(
  parameter int W  = 8,
  parameter int CH = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [CH*W-1:0] seed,
  input  logic [CH*W-1:0] operand,
  input  logic [W-1:0]  len,
  input  logic          hold,
  output logic          busy,
  output logic          bits_valid,
  output logic [CH-1:0] bits,
  output logic          done,
  output logic [CH*W-1:0] ones_cnt
);

  sng_state_e r_state, w_state_next;

  logic [W-1:0]    r_rem;
  logic [CH*W-1:0] r_operand;
  logic            w_load;
  logic            w_step;
  logic [W-1:0]    w_lfsr [CH];
  logic [W-1:0]    r_ones [CH];

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_load       = 1'b1;
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!hold) begin
          w_step = 1'b1;
          if (r_rem == W'(1)) w_state_next = ST_DONE;
        end
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A length of zero selects the full LFSR period, 2^W-1.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rem     <= '0;
      r_operand <= '0;
    end else if (w_load) begin
      r_rem     <= (len == '0) ? '1 : len;
      r_operand <= operand;
    end else if (w_step) begin
      r_rem <= r_rem - W'(1);
    end
  end

  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    sc_lfsr_core #(.W(W)) u_lfsr (
      .clock (clock),
      .reset (reset),
      .load  (w_load),
      .step  (w_step),
      .seed  (seed[gi*W +: W]),
      .state (w_lfsr[gi])
    );

    assign bits[gi] = (w_lfsr[gi] < r_operand[gi*W +: W]);

    always_ff @(posedge clock) begin
      if (reset || w_load) begin
        r_ones[gi] <= '0;
      end else if (w_step) begin
        r_ones[gi] <= r_ones[gi] + W'(bits[gi]);
      end
    end

    assign ones_cnt[gi*W +: W] = r_ones[gi];
  end

  assign busy       = (r_state == ST_RUN);
  assign bits_valid = busy & ~hold;
  assign done       = (r_state == ST_DONE);

endmodule

// File: tb/tb_sc_sng_bank.sv
// Directed, table-driven bench for sc_sng_bank (W=8/CH=4 and W=4/CH=1 instances).
module tb_sc_sng_bank;

  typedef struct {
    logic        use4;
    logic [31:0] seed;
    logic [31:0] op;
    logic [7:0]  len;
    int          hold_at;
    int          hold_n;
    int          pulse_at;
    logic [31:0] exp_ones;
    int          exp_valid;
    int          exp_done;
  } vec_t;

`ifdef SNG_LOCKUP_GUARD_EN
  localparam logic [31:0] LOCK_ONES = 32'd15;
`else
  localparam logic [31:0] LOCK_ONES = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        hold = 1'b0;
  logic        use4 = 1'b0;
  logic [31:0] seed8 = '0;
  logic [31:0] op8 = '0;
  logic [7:0]  len8 = '0;

  logic        start8, start4;
  logic        busy8, valid8, done8;
  logic [3:0]  bits8;
  logic [31:0] ones8;
  logic [3:0]  seed4, op4, len4;
  logic        busy4, valid4, done4;
  logic [0:0]  bits4;
  logic [3:0]  ones4;

  logic        m_busy, m_valid, m_done;
  logic [31:0] m_ones;

  int n_checks = 0;
  int n_fail   = 0;
  int seen_done;

  vec_t vecs [14];

  always #5 clk = ~clk;

  assign start8 = start & ~use4;
  assign start4 = start & use4;
  assign seed4  = seed8[3:0];
  assign op4    = op8[3:0];
  assign len4   = len8[3:0];

  assign m_busy  = use4 ? busy4  : busy8;
  assign m_valid = use4 ? valid4 : valid8;
  assign m_done  = use4 ? done4  : done8;
  assign m_ones  = use4 ? {28'd0, ones4} : ones8;

  sc_sng_bank #(.W(8), .CH(4)) u_dut8 (
    .clock      (clk),
    .reset      (rst),
    .start      (start8),
    .seed       (seed8),
    .operand    (op8),
    .len        (len8),
    .hold       (hold),
    .busy       (busy8),
    .bits_valid (valid8),
    .bits       (bits8),
    .done       (done8),
    .ones_cnt   (ones8)
  );

  sc_sng_bank #(.W(4), .CH(1)) u_dut4 (
    .clock      (clk),
    .reset      (rst),
    .start      (start4),
    .seed       (seed4),
    .operand    (op4),
    .len        (len4),
    .hold       (hold),
    .busy       (busy4),
    .bits_valid (valid4),
    .bits       (bits4),
    .done       (done4),
    .ones_cnt   (ones4)
  );

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic u4, input logic [31:0] s, input logic [31:0] o,
                              input logic [7:0] l, input int ha, input int hn, input int pa,
                              input logic [31:0] eo, input int ev, input int ed);
    vec_t v;
    v.use4 = u4; v.seed = s; v.op = o; v.len = l;
    v.hold_at = ha; v.hold_n = hn; v.pulse_at = pa;
    v.exp_ones = eo; v.exp_valid = ev; v.exp_done = ed;
    return v;
  endfunction

  // Start a run, watch it cycle by cycle (cycle 1 = first cycle after acceptance).
  task automatic run_vec(input int idx, input vec_t v);
    int done_k, valid_n, held_valid;
    logic busy_at_done;
    use4 = v.use4; seed8 = v.seed; op8 = v.op; len8 = v.len; hold = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    done_k = -1; valid_n = 0; held_valid = 0; busy_at_done = 1'b0;
    for (int k = 1; k <= 600; k++) begin
      hold  = (v.hold_n > 0) && (k >= v.hold_at) && (k < v.hold_at + v.hold_n);
      start = (k == v.pulse_at);
      #1;
      if (m_valid) valid_n++;
      if (hold && m_valid) held_valid++;
      if (m_done) begin
        done_k = k;
        busy_at_done = m_busy;
        break;
      end
      @(negedge clk);
    end
    hold = 1'b0;
    check("done_cycle", idx, done_k, v.exp_done);
    check("valid_count", idx, valid_n, v.exp_valid);
    check("valid_while_held", idx, held_valid, 0);
    check("busy_at_done", idx, {31'd0, busy_at_done}, 32'd0);
    check("ones_cnt", idx, m_ones, v.exp_ones);
    @(negedge clk); start = 1'b0;
    #1;
    check("ones_hold_idle", idx, m_ones, v.exp_ones);
    check("idle_after_done", idx, {30'd0, m_busy, m_done}, 32'd0);
    $display("vec %0d: done at cycle %0d, %0d valid bits, ones_cnt 0x%0h", idx, done_k, valid_n, m_ones);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            use4  seed          operand       len    ha  hn pa exp_ones      val  done
    vecs[0]  = mk(1'b1, 32'h0,        32'h5,        8'd0,  0,  0, 0, 32'h5,        15,  16);
    vecs[1]  = mk(1'b1, 32'hF,        32'hF,        8'd0,  0,  0, 0, LOCK_ONES,    15,  16);
    vecs[2]  = mk(1'b0, 32'hC8631100, 32'hFF800100, 8'd0,  0,  0, 0, 32'hFF800100, 255, 256);
    vecs[3]  = mk(1'b0, 32'hC8631100, 32'hFF800100, 8'd0,  100, 3, 0, 32'hFF800100, 255, 259);
    vecs[4]  = mk(1'b0, 32'h0,        32'hFFFFFFFF, 8'd3,  0,  0, 0, 32'h03030303, 3,   4);
    vecs[5]  = mk(1'b0, 32'h0,        32'h00040102, 8'd3,  0,  0, 0, 32'h00030102, 3,   4);
    vecs[6]  = mk(1'b0, 32'h0,        32'h00050001, 8'd1,  0,  0, 0, 32'h00010001, 1,   2);
    vecs[7]  = mk(1'b0, 32'h01010101, 32'h01021008, 8'd4,  0,  0, 0, 32'h00010403, 4,   5);
    vecs[8]  = mk(1'b0, 32'h0,        32'hFFFFFFFF, 8'd3,  2,  2, 0, 32'h03030303, 3,   6);
    vecs[9]  = mk(1'b1, 32'h0,        32'h2,        8'd3,  0,  0, 0, 32'h2,        3,   4);
    vecs[10] = mk(1'b0, 32'h0,        32'hFFFFFFFF, 8'd3,  1,  1, 0, 32'h03030303, 3,   5);
    vecs[11] = mk(1'b0, 32'hC8631100, 32'hFF800100, 8'd255, 0, 0, 0, 32'hFF800100, 255, 256);
    vecs[12] = mk(1'b0, 32'h0,        32'hFFFFFFFF, 8'd10, 0,  0, 4, 32'h0A0A0A0A, 10,  11);
    vecs[13] = mk(1'b0, 32'h0,        32'hFFFFFFFF, 8'd3,  0,  0, 4, 32'h03030303, 3,   4);

    repeat (3) @(negedge clk);
    #1;
    check("reset_ctrl8", 0, {28'd0, busy8, valid8, done8, 1'b0}, 32'd0);
    check("reset_bits8", 0, {28'd0, bits8}, 32'd0);
    check("reset_ones8", 0, ones8, 32'd0);
    check("reset_all4", 0, {24'd0, busy4, valid4, done4, bits4, ones4}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

    // Abandon a run with reset mid-stream, then confirm a clean restart.
    use4 = 1'b0; seed8 = 32'h0; op8 = 32'hFFFFFFFF; len8 = 8'd10;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check("midrun_ones", 14, ones8, 32'h05050505);
    check("midrun_busy", 14, {31'd0, busy8}, 32'd1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1;
    check("abort_busy", 14, {31'd0, busy8}, 32'd0);
    check("abort_ones", 14, ones8, 32'd0);
    check("abort_valid", 14, {31'd0, valid8}, 32'd0);
    seen_done = 0;
    repeat (20) begin
      @(negedge clk); #1;
      if (done8) seen_done++;
    end
    check("abort_no_done", 14, seen_done, 0);
    $display("vec 14: run aborted by reset, %0d done pulses afterwards", seen_done);
    run_vec(15, vecs[4]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
